updown_counter_sequencer: RTL and testbench

//  Command-driven sequencer for the 4-bit up/down counter datapath. Accepts a sweep

---
 rtl/updown_counter_sequencer.sv | 157 +++++++++++++++
 tb/tb_updown_counter_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_sequencer.sv
// Command-driven sweep sequencer that owns one 4-bit up/down counter.
// It accepts a sweep command (target, one-shot/bounce mode, loop count) and
// drives the counter's reset/upDown/enable controls. It watches the returned
// count so that every sweep stops exactly on its end value.
// Optional feature: define UDSEQ_WATCHDOG_EN to add a stall watchdog.
// The watchdog pulses err and returns to IDLE when the counter stops moving.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_target/bounce/loops   sweep top value, bounce mode, extra bounce repeats
//   abort                     cancel the active command
//   ctr_count                 registered count returned by the counter
//   ctr_reset/upDown/enable   counter controls, decoded from state + count
//   busy, done, err           status: not idle, completion pulse, watchdog pulse
//   loops_left                remaining bounce repeats
module updown_counter_sequencer #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOOP_W      = 4,
  parameter int unsigned WDOG_CYCLES = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic              cmd_bounce,
  input  logic [LOOP_W-1:0] cmd_loops,
  input  logic              abort,
  input  logic [WIDTH-1:0]  ctr_count,
  output logic              ctr_reset,
  output logic              ctr_upDown,
  output logic              ctr_enable,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LOOP_W-1:0] loops_left
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_UP    = 3'd2;
  localparam logic [2:0] ST_DOWN  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  if (WDOG_CYCLES == 0) begin : g_bad_wdog
    $error("WDOG_CYCLES must be nonzero");
  end

  logic [2:0]        state, state_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic              bounce_q, bounce_d;
  logic [LOOP_W-1:0] loops_q, loops_d;
  logic              enable_c;
  logic              trip;

  // Counter enable: stop exactly on the sweep end value; abort freezes the count.
  always_comb begin
    enable_c = 1'b0;
    if (state == ST_UP)   enable_c = (ctr_count != target_q);
    if (state == ST_DOWN) enable_c = (ctr_count != '0);
    if (abort)            enable_c = 1'b0;
  end

`ifdef UDSEQ_WATCHDOG_EN
  localparam int unsigned STALL_W = $clog2(WDOG_CYCLES + 1);

  logic [STALL_W-1:0] stall_q;
  logic [WIDTH-1:0]   last_count_q;
  logic [2:0]         last_state_q;
  logic               stalled;
  logic               err_q;

  // A stalled cycle is one that is enabled in the same sweep state with no count movement.
  assign stalled = ((state == ST_UP) || (state == ST_DOWN)) && enable_c &&
                   (ctr_count == last_count_q) && (state == last_state_q);
  assign trip    = stalled && (stall_q == STALL_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q      <= '0;
      last_count_q <= '0;
      last_state_q <= ST_IDLE;
      err_q        <= 1'b0;
    end else begin
      stall_q      <= (stalled && !trip) ? stall_q + STALL_W'(1) : '0;
      last_count_q <= ctr_count;
      last_state_q <= state;
      err_q        <= trip;
    end
  end

  assign err = err_q && !reset;
`else
  assign trip = 1'b0;
  assign err  = 1'b0;
`endif

  // Next-state and latched command fields.
  always_comb begin
    state_d  = state;
    target_d = target_q;
    bounce_d = bounce_q;
    loops_d  = loops_q;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && !abort) begin
          target_d = cmd_target;
          bounce_d = cmd_bounce;
          loops_d  = cmd_loops;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_UP;
      ST_UP: begin
        if (ctr_count == target_q) state_d = bounce_q ? ST_DOWN : ST_DONE;
      end
      ST_DOWN: begin
        if (ctr_count == '0) begin
          if (loops_q == '0) begin
            state_d = ST_DONE;
          end else begin
            loops_d = loops_q - LOOP_W'(1);
            state_d = ST_UP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if ((abort && (state != ST_IDLE)) || trip) state_d = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      target_q <= '0;
      bounce_q <= 1'b0;
      loops_q  <= '0;
    end else begin
      state    <= state_d;
      target_q <= target_d;
      bounce_q <= bounce_d;
      loops_q  <= loops_d;
    end
  end

  // Counter is held in reset while this block is in reset.
  // Every other output is forced to 0 during reset.
  assign ctr_reset  = reset || (state == ST_CLEAR);
  assign ctr_upDown = !reset && (state == ST_UP);
  assign ctr_enable = !reset && enable_c;
  assign cmd_ready  = !reset && (state == ST_IDLE) && !abort;
  assign busy       = !reset && (state != ST_IDLE);
  assign done       = !reset && (state == ST_DONE);
  assign loops_left = reset ? '0 : loops_q;

endmodule

// File: tb/tb_updown_counter_sequencer.sv
module tb_updown_counter_sequencer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_target;
  logic       cmd_bounce;
  logic [3:0] cmd_loops;
  logic       abort;
  logic [3:0] ctr_count;
  logic       ctr_reset;
  logic       ctr_upDown;
  logic       ctr_enable;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] loops_left;

  logic       freeze;

  typedef struct {
    logic [3:0] count;
    logic       enable;
    logic       done;
    logic [3:0] loops;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  updown_counter_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_bounce (cmd_bounce),
    .cmd_loops  (cmd_loops),
    .abort      (abort),
    .ctr_count  (ctr_count),
    .ctr_reset  (ctr_reset),
    .ctr_upDown (ctr_upDown),
    .ctr_enable (ctr_enable),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .loops_left (loops_left)
  );

  // Behavioural 4-bit up/down counter; freeze models a stuck counter.
  always_ff @(posedge clock) begin
    if (ctr_reset)                 ctr_count <= 4'd0;
    else if (ctr_enable && !freeze) ctr_count <= ctr_upDown ? ctr_count + 4'd1 : ctr_count - 4'd1;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (ctr_reset !== 1'b1) begin errors++; $display("FAIL rst_ctr_reset got %0b want 1", ctr_reset); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset got %0b want 0", cmd_ready); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL rst_ready got %0b want 1", cmd_ready); end
    checks++; if (ctr_enable !== 1'b0) begin errors++; $display("FAIL rst_enable got %0b want 0", ctr_enable); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done got %0b want 0", done); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rst_err got %0b want 0", err); end
    checks++; if (ctr_count !== 4'd0)  begin errors++; $display("FAIL rst_count got %0d want 0", ctr_count); end
  endtask

  // Pushes the expected per-cycle trace, issues the command, then pops and compares one entry per cycle.
  task automatic test_sweep(input int t, input bit b, input int l);
    exp_t e;
    int   reps;
    reps = b ? l : 0;
    for (int r = 0; r <= reps; r++) begin
      for (int v = 0; v <= t; v++)
        sb.push_back('{count: 4'(v), enable: (v != t), done: 1'b0, loops: 4'(b ? l - r : l)});
      if (b)
        for (int v = t; v >= 0; v--)
          sb.push_back('{count: 4'(v), enable: (v != 0), done: 1'b0, loops: 4'(l - r)});
    end
    sb.push_back('{count: 4'(b ? 0 : t), enable: 1'b0, done: 1'b1, loops: 4'(b ? 0 : l)});

    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_target = 4'(t); cmd_bounce = b; cmd_loops = 4'(l);
    @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready T=%0d got %0b want 1", t, cmd_ready); end
    @(posedge clock); #1 cmd_valid = 1'b0;
    @(negedge clock);
    checks++; if (ctr_reset !== 1'b1 || busy !== 1'b1 || ctr_enable !== 1'b0)
      begin errors++; $display("FAIL sweep_clear T=%0d got rst=%0b busy=%0b en=%0b want 1 1 0", t, ctr_reset, busy, ctr_enable); end
    for (int c = 0; sb.size() > 0; c++) begin
      @(negedge clock);
      e = sb.pop_front();
      checks++; if (ctr_count !== e.count)  begin errors++; $display("FAIL sweep_count T=%0d cyc=%0d got %0d want %0d", t, c, ctr_count, e.count); end
      checks++; if (ctr_enable !== e.enable) begin errors++; $display("FAIL sweep_enable T=%0d cyc=%0d got %0b want %0b", t, c, ctr_enable, e.enable); end
      checks++; if (done !== e.done)        begin errors++; $display("FAIL sweep_done T=%0d cyc=%0d got %0b want %0b", t, c, done, e.done); end
      checks++; if (loops_left !== e.loops) begin errors++; $display("FAIL sweep_loops T=%0d cyc=%0d got %0d want %0d", t, c, loops_left, e.loops); end
    end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL sweep_idle T=%0d got busy=%0b done=%0b ready=%0b want 0 0 1", t, busy, done, cmd_ready); end
    checks++; if (ctr_count !== 4'(b ? 0 : t)) begin errors++; $display("FAIL sweep_hold T=%0d got %0d want %0d", t, ctr_count, b ? 0 : t); end
  endtask

  task automatic test_abort();
    bit found;
    found = 1'b0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_target = 4'd9; cmd_bounce = 1'b0; cmd_loops = 4'd0;
    @(posedge clock); #1 cmd_target = 4'd1;
    @(negedge clock);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %0b want 0", cmd_ready); end
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (ctr_count == 4'd2 && ctr_upDown) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_wait got timeout want count 2"); end
    abort = 1'b1;
    #1;
    checks++; if (ctr_enable !== 1'b0) begin errors++; $display("FAIL abort_enable got %0b want 0", ctr_enable); end
    @(posedge clock); #1 abort = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%0b done=%0b want 0 0", busy, done); end
    checks++; if (ctr_count !== 4'd2) begin errors++; $display("FAIL abort_hold got %0d want 2", ctr_count); end
    @(negedge clock);
    checks++; if (ctr_count !== 4'd2 || done !== 1'b0) begin errors++; $display("FAIL abort_hold2 got cnt=%0d done=%0b want 2 0", ctr_count, done); end

    // Abort together with cmd_valid in IDLE: command is not taken.
    @(posedge clock); #1 abort = 1'b1; cmd_valid = 1'b1; cmd_target = 4'd3;
    @(negedge clock);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_ready got %0b want 0", cmd_ready); end
    @(posedge clock); #1 abort = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %0b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_target = 4'd7; cmd_bounce = 1'b1; cmd_loops = 4'd3;
    @(posedge clock); #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    checks++; if (ctr_reset !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_out got rst=%0b busy=%0b want 1 0", ctr_reset, busy); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || loops_left !== 4'd0 || ctr_count !== 4'd0)
      begin errors++; $display("FAIL midrst_idle got busy=%0b loops=%0d cnt=%0d want 0 0 0", busy, loops_left, ctr_count); end
  endtask

`ifdef UDSEQ_WATCHDOG_EN
  task automatic test_watchdog();
    bit found;
    int k;
    found = 1'b0;
    k = 0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_target = 4'd9; cmd_bounce = 1'b0; cmd_loops = 4'd0;
    @(posedge clock); #1 cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (ctr_count == 4'd4) found = 1'b1;
    end
    freeze = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 15 && !found; i++) begin
      @(negedge clock);
      if (err) begin found = 1'b1; k = i; end
    end
    checks++; if (k != 9) begin errors++; $display("FAIL wdog_latency got %0d want 9", k); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL wdog_idle got busy=%0b done=%0b want 0 0", busy, done); end
    @(negedge clock);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wdog_pulse got %0b want 0", err); end
    freeze = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_target = 4'd0; cmd_bounce = 1'b0;
    cmd_loops = 4'd0; abort = 1'b0; freeze = 1'b0;
    test_reset();
    test_sweep(5, 1'b0, 2);
    test_sweep(3, 1'b1, 1);
    test_sweep(15, 1'b0, 0);
    test_sweep(0, 1'b0, 0);
    test_sweep(0, 1'b1, 2);
    test_abort();
    test_mid_reset();
    test_sweep(2, 1'b1, 0);
`ifdef UDSEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
